fpga_cfg_loader: RTL
====================

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: prog_clk half-period in wb_clk_i cycles; legal range 1..255.
REQ-002 SHALL have ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address; only bits [3:2] decoded
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- prog_clk  out  1  fabric configuration clock
- prog_reset  out  1  fabric configuration reset
- ccff_head  out  1  serial configuration data into the chain
- ccff_tail  in  1  serial chain output
- isol_n  out  1  fabric I/O isolation, active-low
- done_o  out  1  word-complete pulse, usable as user_irq

Function
REQ-003 SHALL decode registers by wbs_adr_i[3:2]:
- 0 CTRL: bit0 = prog_reset, bit1 = isol_n; R/W.
- 1 STATUS: bit0 = busy, bit1 = done (sticky); any write clears done.
- 2 DATA: write-only; reads return 0.
- 3 TAIL: read-only; holds the last 32 captured ccff_tail bits.
REQ-004 SHALL start an access when wbs_stb_i & wbs_cyc_i are high and wbs_ack_o is low.
REQ-005 SHALL assert wbs_ack_o for exactly one cycle per access, and never in two consecutive cycles.
REQ-006 SHALL acknowledge reads and non-DATA writes in the cycle after the request; wbs_dat_o is valid in the ack cycle and 0 otherwise.
REQ-007 SHALL acknowledge a DATA write in the cycle after it is accepted. It is accepted when the FSM is IDLE; while busy, ack is withheld until the FSM returns to IDLE.
REQ-008 SHALL use FSM states IDLE, LOW and HIGH:
- IDLE -> LOW when a DATA word is accepted; the word is loaded into the shift register and the bit counter is set to 31.
- LOW -> HIGH after CLK_DIV cycles.
- HIGH -> LOW after CLK_DIV cycles while the counter is > 0; the counter decrements.
- HIGH -> IDLE after CLK_DIV cycles when the counter is 0.
REQ-009 SHALL drive prog_clk 0 in IDLE and LOW and 1 in HIGH, registered and glitch-free.
REQ-010 SHALL shift MSB first: ccff_head equals the current bit throughout LOW and HIGH. In IDLE, ccff_head holds the last bit shifted.
REQ-011 SHALL shift ccff_tail into TAIL (LSB entry) on the LOW->HIGH transition.
REQ-012 SHALL hold busy = 1 in LOW and HIGH; one word occupies exactly 64*CLK_DIV cycles.
REQ-013 SHALL, on HIGH->IDLE, pulse done_o high for one cycle and set STATUS.done.
REQ-014 SHALL abort an in-progress shift when CTRL is written with bit0 = 1: next state IDLE, prog_clk 0, no done. A DATA write stalled at that point is then accepted normally.
REQ-015 SHALL let STATUS.done set take priority over a same-cycle STATUS write clear.
REQ-016 SHALL drive prog_reset and isol_n directly from the CTRL register bits.

Reset
REQ-017 SHALL, while wb_rst_i is high, force:
- prog_reset = 1, isol_n = 0, prog_clk = 0, ccff_head = 0
- wbs_ack_o = 0, wbs_dat_o = 0, done_o = 0
- FSM = IDLE; TAIL, done, shift register and counter = 0
REQ-018 SHALL abandon any in-progress shift or pending ack when wb_rst_i asserts mid-operation, with no done_o pulse.

Verification
REQ-019 Reset, then read CTRL -> ack one cycle later, data 0x00000001; STATUS reads 0.
REQ-020 With CLK_DIV = 2, write DATA 0xA5000000:
- ack one cycle later; exactly 32 prog_clk pulses over 128 cycles.
- ccff_head sequence starts 1,0,1,0,0,1,0,1.
- done_o pulses once; STATUS reads 0x2.
REQ-021 Loop ccff_tail to ccff_head through a 32-stage external shift model, write DATA 0x12345678 twice -> TAIL reads 0x12345678 after the second word.
REQ-022 Issue a second DATA write while busy -> ack withheld until IDLE; the second word starts the cycle after the first completes; two done_o pulses total.
REQ-023 Write CTRL 0x1 at bit 10 of a shift -> prog_clk low and busy 0 within 2 cycles; no done_o pulse.
REQ-024 Assert wb_rst_i mid-shift -> all outputs at reset values the next cycle; a subsequent DATA write shifts normally.

Source files
------------

// File: rtl/fpga_cfg_loader.sv
// Wishbone-mapped serial configuration loader for an FPGA fabric chain.
// Shifts 32-bit words MSB first on ccff_head with a divided prog_clk.
module fpga_cfg_loader #(
  parameter int CLK_DIV = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk,
  output logic        prog_reset,
  output logic        ccff_head,
  input  logic        ccff_tail,
  output logic        isol_n,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_DATA = 2'd2;
  localparam logic [1:0] A_TAIL = 2'd3;

  state_t      state;
  logic [31:0] sreg;
  logic [31:0] tail;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic        done;
  logic        ctrl_rst;
  logic        ctrl_isol;
  logic [31:0] rdata;

  logic        req;
  logic        wr;
  logic [1:0]  adr;
  logic        busy;
  logic        data_wr;
  logic        data_go;
  logic        stall;
  logic        abort;
  logic        div_end;

  logic unused;
  assign unused = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  assign adr     = wbs_adr_i[3:2];
  assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr      = req & wbs_we_i;
  assign busy    = (state != IDLE);
  assign data_wr = wr & (adr == A_DATA);
  assign data_go = data_wr & ~busy;
  assign stall   = data_wr & busy;
  assign abort   = wr & (adr == A_CTRL) & wbs_dat_i[0];
  assign div_end = (div_cnt == DIV_M1);

  assign ccff_head  = sreg[31];
  assign prog_reset = ctrl_rst;
  assign isol_n     = ctrl_isol;

  // Register read mux
  always_comb begin
    rdata = 32'd0;
    unique case (adr)
      A_CTRL: rdata = {30'd0, ctrl_isol, ctrl_rst};
      A_STAT: rdata = {30'd0, done, busy};
      A_DATA: rdata = 32'd0;
      A_TAIL: rdata = tail;
      default: rdata = 32'd0;
    endcase
  end

  // Bus side: single-cycle ack, read data, control register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      ctrl_rst  <= 1'b1;
      ctrl_isol <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      if (req && !stall) begin
        wbs_ack_o <= 1'b1;
        if (!wbs_we_i) wbs_dat_o <= rdata;
        if (wr && adr == A_CTRL) begin
          ctrl_rst  <= wbs_dat_i[0];
          ctrl_isol <= wbs_dat_i[1];
        end
      end
    end
  end

  // Shift FSM: LOW/HIGH halves of each prog_clk period
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      sreg     <= 32'd0;
      tail     <= 32'd0;
      bit_cnt  <= 5'd0;
      div_cnt  <= 8'd0;
      done     <= 1'b0;
      done_o   <= 1'b0;
      prog_clk <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (wr && adr == A_STAT) done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (data_go) begin
            sreg    <= wbs_dat_i;
            bit_cnt <= 5'd31;
            div_cnt <= 8'd0;
            state   <= LOW;
          end
        end
        LOW: begin
          if (div_end) begin
            div_cnt  <= 8'd0;
            prog_clk <= 1'b1;
            tail     <= {tail[30:0], ccff_tail};
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (div_end) begin
            div_cnt  <= 8'd0;
            prog_clk <= 1'b0;
            if (bit_cnt != 5'd0) begin
              bit_cnt <= bit_cnt - 5'd1;
              sreg    <= {sreg[30:0], 1'b0};
              state   <= LOW;
            end else begin
              state <= IDLE;
              if (!abort) begin
                done_o <= 1'b1;
                done   <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (abort) begin
        state    <= IDLE;
        prog_clk <= 1'b0;
        div_cnt  <= 8'd0;
      end
    end
  end

endmodule
